// File: rtl/ahb_lite_master_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite master port among NREQ requesters.
// Ports: HCLK/HRESETn; REQ/REQ_WRITE/REQ_ADDR/REQ_WDATA in; GNT/DONE/RDATA out;
// AHB side HADDR/HWRITE/HTRANS/HWDATA out, HRDATA/HREADY in.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module ahb_lite_master_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  REQ_WRITE,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]  GNT,
  output logic [NREQ-1:0]  DONE,
  output logic [DW-1:0]    RDATA,
  output logic [AW-1:0]    HADDR,
  output logic             HWRITE,
  output logic [1:0]       HTRANS,
  output logic [DW-1:0]    HWDATA,
  input  logic [DW-1:0]    HRDATA,
  input  logic             HREADY
);

  localparam int IW = $clog2(NREQ);

  // State is the pair {ap_valid, dp_valid}.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b10,
    S_AD   = 2'b11,
    S_DATA = 2'b01
  } state_t;

  state_t          state, state_nx;
  logic            ap_valid, dp_valid;
  logic [IW-1:0]   ap_owner, dp_owner;
  logic [DW-1:0]   ap_wdata;
  logic            dp_write;
  logic [NREQ-1:0] eff;
  logic [IW-1:0]   win, base;
  logic            any;
  logic [NREQ-1:0] gnt_nx, done_nx;

  assign ap_valid = state[1];
  assign dp_valid = state[0];

  // A requester just granted still shows REQ this cycle; mask it out.
  assign eff = REQ & ~GNT;

`ifdef ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IW-1:0] ptr, ptr_nx;
  assign base = ptr;
  assign ptr_nx = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr <= '0;
    end else if (HREADY && any) begin
      ptr <= ptr_nx;
    end
  end
`endif

  // First set bit of eff searching upward from base, wrapping.
  always_comb begin
    int idx;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(base) + i) % NREQ;
      if (!any && eff[idx]) begin
        any = 1'b1;
        win = IW'(idx);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (HREADY) state_nx = state_t'({any, ap_valid});
  end

  always_comb begin
    gnt_nx  = '0;
    done_nx = '0;
    if (HREADY) begin
      if (any)      gnt_nx[win]       = 1'b1;
      if (dp_valid) done_nx[dp_owner] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      GNT      <= '0;
      DONE     <= '0;
      RDATA    <= '0;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HTRANS   <= 2'b00;
      HWDATA   <= '0;
      ap_owner <= '0;
      ap_wdata <= '0;
      dp_owner <= '0;
      dp_write <= 1'b0;
    end else begin
      GNT  <= gnt_nx;
      DONE <= done_nx;
      if (HREADY) begin
        if (dp_valid && !dp_write) RDATA <= HRDATA;
        dp_owner <= ap_owner;
        dp_write <= HWRITE;
        HWDATA   <= ap_wdata;
        HTRANS   <= any ? 2'b10 : 2'b00;
        if (any) begin
          ap_owner <= win;
          HADDR    <= REQ_ADDR[win*AW +: AW];
          HWRITE   <= REQ_WRITE[win];
          ap_wdata <= REQ_WDATA[win*DW +: DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench for ahb_lite_master_arbiter (default round-robin build, NREQ=4).
// Per-cycle vector table plus hand sequences for wait states and mid-transfer reset.
module tb_ahb_lite_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [3:0]  REQ = '0;
  logic [3:0]  REQ_WRITE = '0;
  logic [127:0] REQ_ADDR;
  logic [127:0] REQ_WDATA;
  logic [3:0]  GNT, DONE;
  logic [31:0] RDATA, HADDR, HWDATA;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;

  int total = 0;
  int bad = 0;

  ahb_lite_master_arbiter #(.NREQ(4), .AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  always #5 HCLK = ~HCLK;

  // Fixed per-requester address and write data.
  assign REQ_ADDR  = {32'h300, 32'h200, 32'h100, 32'h000};
  assign REQ_WDATA = {32'h33333333, 32'h22222222,
                      32'hDEADBEEF, 32'hA0A0A0A0};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] hrdata;
    logic        hready;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [1:0]  htrans;
    logic        cka;
    logic [31:0] haddr;
    logic        hwrite;
    logic        ckw;
    logic [31:0] hwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(
    input logic [3:0] req, input logic [3:0] wr,
    input logic [31:0] hrd, input logic rdy,
    input logic [3:0] gnt, input logic [3:0] done,
    input logic [1:0] ht, input logic cka,
    input logic [31:0] ha, input logic hw,
    input logic ckw, input logic [31:0] hwd,
    input logic [31:0] rd);
    vec_t v;
    v.req = req; v.wr = wr; v.hrdata = hrd; v.hready = rdy;
    v.gnt = gnt; v.done = done; v.htrans = ht; v.cka = cka;
    v.haddr = ha; v.hwrite = hw; v.ckw = ckw; v.hwdata = hwd;
    v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] req, input logic [3:0] wr,
                     input logic [31:0] hrd, input logic rdy);
    REQ = req; REQ_WRITE = wr; HRDATA = hrd; HREADY = rdy;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    // contention: REQ held at 1111, order 0,1,2,3,0
    tbl[0]  = mk(4'hF, 4'hA, 32'h0,    1, 4'h1, 4'h0, 2'b10, 1, 32'h000, 0, 0, 0, 32'h0);
    tbl[1]  = mk(4'hF, 4'hA, 32'h0,    1, 4'h2, 4'h0, 2'b10, 1, 32'h100, 1, 0, 0, 32'h0);
    tbl[2]  = mk(4'hF, 4'hA, 32'hAAAA, 1, 4'h4, 4'h1, 2'b10, 1, 32'h200, 0, 1, 32'hDEADBEEF, 32'hAAAA);
    tbl[3]  = mk(4'hF, 4'hA, 32'hBBBB, 1, 4'h8, 4'h2, 2'b10, 1, 32'h300, 1, 0, 0, 32'hAAAA);
    tbl[4]  = mk(4'hF, 4'hA, 32'hCCCC, 1, 4'h1, 4'h4, 2'b10, 1, 32'h000, 0, 1, 32'h33333333, 32'hCCCC);
    tbl[5]  = mk(4'h0, 4'h0, 32'hDDDD, 1, 4'h0, 4'h8, 2'b00, 0, 0, 0, 0, 0, 32'hCCCC);
    tbl[6]  = mk(4'h0, 4'h0, 32'hEEEE, 1, 4'h0, 4'h1, 2'b00, 0, 0, 0, 0, 0, 32'hEEEE);
    tbl[7]  = mk(4'h0, 4'h0, 32'h0,    1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hEEEE);
    // single write from requester 1
    tbl[8]  = mk(4'h2, 4'h2, 32'h0,    1, 4'h2, 4'h0, 2'b10, 1, 32'h100, 1, 0, 0, 32'hEEEE);
    tbl[9]  = mk(4'h0, 4'h0, 32'h0,    1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 1, 32'hDEADBEEF, 32'hEEEE);
    tbl[10] = mk(4'h0, 4'h0, 32'h0,    1, 4'h0, 4'h2, 2'b00, 0, 0, 0, 0, 0, 32'hEEEE);
    tbl[11] = mk(4'h0, 4'h0, 32'h0,    1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hEEEE);
    // single read from requester 2
    tbl[12] = mk(4'h4, 4'h0, 32'h0,    1, 4'h4, 4'h0, 2'b10, 1, 32'h200, 0, 0, 0, 32'hEEEE);
    tbl[13] = mk(4'h0, 4'h0, 32'h0,    1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 32'hEEEE);
    tbl[14] = mk(4'h0, 4'h0, 32'h12345678, 1, 4'h0, 4'h4, 2'b00, 0, 0, 0, 0, 0, 32'h12345678);
    tbl[15] = mk(4'h0, 4'h0, 32'hFFFFFFFF, 1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 32'h12345678);
    // write (req 3) then read (req 0) back-to-back, pointer now at 3
    tbl[16] = mk(4'h9, 4'h8, 32'h0,    1, 4'h8, 4'h0, 2'b10, 1, 32'h300, 1, 0, 0, 32'h12345678);
    tbl[17] = mk(4'h1, 4'h0, 32'h0,    1, 4'h1, 4'h0, 2'b10, 1, 32'h000, 0, 1, 32'h33333333, 32'h12345678);
    tbl[18] = mk(4'h0, 4'h0, 32'hBAD,  0, 4'h0, 4'h0, 2'b10, 1, 32'h000, 0, 1, 32'h33333333, 32'h12345678);
    tbl[19] = mk(4'h0, 4'h0, 32'hBAD,  0, 4'h0, 4'h0, 2'b10, 1, 32'h000, 0, 1, 32'h33333333, 32'h12345678);

    // reset
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    @(posedge HCLK);
    @(posedge HCLK);
    #2 HRESETn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].req, tbl[i].wr, tbl[i].hrdata, tbl[i].hready);
      chk($sformatf("v%0d_gnt", i), 32'(GNT), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_done", i), 32'(DONE), 32'(tbl[i].done));
      chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(tbl[i].htrans));
      chk($sformatf("v%0d_rdata", i), RDATA, tbl[i].rdata);
      if (tbl[i].cka) begin
        chk($sformatf("v%0d_haddr", i), HADDR, tbl[i].haddr);
        chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(tbl[i].hwrite));
      end
      if (tbl[i].ckw)
        chk($sformatf("v%0d_hwdata", i), HWDATA, tbl[i].hwdata);
    end

    // third stall cycle, then release: write completes, then read
    cyc(4'h0, 4'h0, 32'hBAD, 1'b0);
    chk("ws3_gnt", 32'(GNT), 32'h0);
    chk("ws3_done", 32'(DONE), 32'h0);
    chk("ws3_htrans", 32'(HTRANS), 32'h2);
    chk("ws3_haddr", HADDR, 32'h0);
    chk("ws3_hwdata", HWDATA, 32'h33333333);
    cyc(4'h0, 4'h0, 32'h55, 1'b1);
    chk("ws_wr_done", 32'(DONE), 32'h8);
    chk("ws_wr_rdata", RDATA, 32'h12345678);
    chk("ws_wr_htrans", 32'(HTRANS), 32'h0);
    cyc(4'h0, 4'h0, 32'h0A0B0C0D, 1'b1);
    chk("ws_rd_done", 32'(DONE), 32'h1);
    chk("ws_rd_rdata", RDATA, 32'h0A0B0C0D);
    cyc(4'h0, 4'h0, 32'h0, 1'b1);
    chk("ws_end_done", 32'(DONE), 32'h0);

    // reach ADDR_DATA (pointer at 1, then 3), then reset mid-cycle
    cyc(4'h2, 4'h0, 32'h0, 1'b1);
    chk("mr_gnt1", 32'(GNT), 32'h2);
    cyc(4'h4, 4'h0, 32'h0, 1'b1);
    chk("mr_gnt2", 32'(GNT), 32'h4);
    chk("mr_ad_htrans", 32'(HTRANS), 32'h2);
    REQ = 4'h0;
    #2 HRESETn = 1'b0;
    #1;
    chk("mr_htrans", 32'(HTRANS), 32'h0);
    chk("mr_haddr", HADDR, 32'h0);
    chk("mr_gnt", 32'(GNT), 32'h0);
    chk("mr_done", 32'(DONE), 32'h0);
    @(posedge HCLK);
    #1;
    chk("mr_hold_done", 32'(DONE), 32'h0);
    HRESETn = 1'b1;
    cyc(4'hA, 4'h0, 32'h0, 1'b1);
    chk("mr_post_gnt", 32'(GNT), 32'h2);
    chk("mr_post_haddr", HADDR, 32'h100);
    chk("mr_post_done", 32'(DONE), 32'h0);
    cyc(4'h8, 4'h0, 32'h0, 1'b1);
    chk("mr_post_gnt3", 32'(GNT), 32'h8);
    chk("mr_post_done2", 32'(DONE), 32'h0);
    cyc(4'h0, 4'h0, 32'h77, 1'b1);
    chk("mr_post_done1", 32'(DONE), 32'h2);
    chk("mr_post_rdata", RDATA, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
